// File: rtl/debug_frame_serializer_pkg.sv
// Shared uart/debug constants for the debug frame serializer.
//   DBG_NB_DATA       UART byte width
//   DBG_FRAME_HEADER  first byte of every debug frame
//   NB_ID_EX/...      widths of the pipeline debug buses that can be framed
//   dbg_state_t       serializer FSM encoding (2 bits)
package debug_frame_serializer_pkg;

  localparam int unsigned DBG_NB_DATA = 8;
  localparam logic [DBG_NB_DATA-1:0] DBG_FRAME_HEADER = 8'hA5;

  localparam int unsigned NB_ID_EX  = 144;
  localparam int unsigned NB_EX_MEM = 32;
  localparam int unsigned NB_MEM_WB = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } dbg_state_t;

endpackage

// File: rtl/debug_frame_serializer.sv
// Serializes a snapshot of a wide debug bus into a UART frame:
// HEADER, N_PAYLOAD bytes MSB-first, XOR checksum of the payload bytes.
// Ports:
//   clk        system clock, rising edge
//   i_rst      asynchronous reset, active-high
//   i_start    frame request, only honoured while idle
//   i_frame    debug snapshot; byte N_PAYLOAD-1 sits in the top bits
//   i_txDone   byte-finished pulse from uart_tx
//   o_tx_start one-cycle send request to uart_tx
//   o_data     byte for uart_tx, held until i_txDone
//   o_busy     frame in progress
//   o_done     one-cycle pulse once the checksum byte has gone out
module debug_frame_serializer
  import debug_frame_serializer_pkg::*;
#(
  parameter int unsigned        NB_DATA   = DBG_NB_DATA,
  parameter int unsigned        N_PAYLOAD = NB_ID_EX / DBG_NB_DATA,
  parameter logic [NB_DATA-1:0] HEADER    = NB_DATA'(DBG_FRAME_HEADER)
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [NB_DATA*N_PAYLOAD-1:0] i_frame,
  input  logic                         i_txDone,
  output logic                         o_tx_start,
  output logic [NB_DATA-1:0]           o_data,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned NB_FRAME = NB_DATA * N_PAYLOAD;
  localparam int unsigned IDX_W    = $clog2(N_PAYLOAD + 2);
  localparam int unsigned POS_W    = $clog2(NB_FRAME);
  localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(N_PAYLOAD + 1);

  dbg_state_t            state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic [NB_FRAME-1:0]   shadow, shadow_d;
  logic [NB_DATA-1:0]    csum, csum_d;
  logic [NB_DATA-1:0]    data_d;
  logic                  tx_start_d, busy_d, done_d;
  logic                  txdone_prev;

  logic                  txdone_rise_c;
  logic                  is_payload_c;
  logic [POS_W-1:0]      sel_base_c;
  logic [NB_DATA-1:0]    payload_byte_c;
  logic [NB_DATA-1:0]    tx_byte_c;

  // A held i_txDone must count once, so only its rising edge advances the frame.
  assign txdone_rise_c = i_txDone & ~txdone_prev;

  // Byte to send for the current index; payload index 1 maps to the top byte.
  always_comb begin
    is_payload_c = (idx != '0) && (idx != IDX_CSUM);
    sel_base_c   = '0;
    if (is_payload_c) begin
      sel_base_c = POS_W'((N_PAYLOAD - 32'(idx)) * NB_DATA);
    end
    payload_byte_c = shadow[sel_base_c +: NB_DATA];
    if (idx == '0) begin
      tx_byte_c = HEADER;
    end else if (idx == IDX_CSUM) begin
      tx_byte_c = csum;
    end else begin
      tx_byte_c = payload_byte_c;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    shadow_d   = shadow;
    csum_d     = csum;
    data_d     = o_data;
    tx_start_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          shadow_d = i_frame;
          idx_d    = '0;
          csum_d   = '0;
          busy_d   = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_start_d = 1'b1;
        data_d     = tx_byte_c;
        busy_d     = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        if (txdone_rise_c) begin
          if (is_payload_c) begin
            csum_d = csum ^ o_data;
          end
          if (idx == IDX_CSUM) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      shadow      <= '0;
      csum        <= '0;
      txdone_prev <= 1'b0;
      o_tx_start  <= 1'b0;
      o_data      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      shadow      <= shadow_d;
      csum        <= csum_d;
      txdone_prev <= i_txDone;
      o_tx_start  <= tx_start_d;
      o_data      <= data_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
    end
  end

endmodule
